// File: rtl/timer_share_scheduler.sv
// Round-robin sharing of one external down counter among REQ one-shot timeout clients.
// Define TIMER_SHARE_STATS_EN to add the saturating served_cnt completion counter.
module timer_share_scheduler #(
   parameter int N   = 8,
   parameter int REQ = 4,
   parameter int PW  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REQ-1:0]   req,
   input  logic [REQ*N-1:0] req_value,
   output logic [REQ-1:0]   grant,
   output logic [REQ-1:0]   done,
   output logic             busy,
   input  logic [N-1:0]     cnt_value,
   output logic             cnt_preset,
   output logic [N-1:0]     cnt_preset_value,
   output logic             cnt_up_en,
   output logic             cnt_dn_en,
   output logic             cnt_pause
`ifdef TIMER_SHARE_STATS_EN
   ,
   output logic [15:0]      served_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state;
   logic [PW-1:0] rr;
   logic [PW-1:0] owner;
   logic [N-1:0]  lv;
   logic          pick_vld;
   logic [PW-1:0] pick_idx;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (int'(p) == REQ - 1) ? '0 : p + 1'b1;
   endfunction

   // Scan downward so the last hit written is the first set bit at or after rr.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
      for (int k = REQ - 1; k >= 0; k--) begin
         idx = (int'(rr) + k) % REQ;
         if (req[idx]) begin
            pick_vld = 1'b1;
            pick_idx = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
         rr    <= '0;
         owner <= '0;
         lv    <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state <= LOAD;
                  busy  <= 1'b1;
                  grant <= REQ'(1) << pick_idx;
                  owner <= pick_idx;
                  lv    <= req_value[pick_idx*N +: N];
               end
            end
            LOAD: begin
               if (!req[owner]) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  grant <= '0;
                  rr    <= next_ptr(owner);
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               // A dropped request wins over a simultaneous zero detect.
               if (!req[owner]) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  grant <= '0;
                  rr    <= next_ptr(owner);
               end else if (cnt_value == '0) begin
                  state <= DONE;
                  done  <= grant;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               grant <= '0;
               rr    <= next_ptr(owner);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Counter control is a pure decode; pausing at zero keeps the counter from wrapping.
   always_comb begin
      cnt_up_en        = 1'b0;
      cnt_preset_value = lv;
      cnt_preset       = 1'b0;
      cnt_dn_en        = 1'b0;
      cnt_pause        = 1'b1;
      case (state)
         LOAD: begin
            cnt_preset = 1'b1;
            cnt_dn_en  = 1'b1;
            cnt_pause  = 1'b0;
         end
         RUN: begin
            cnt_dn_en = 1'b1;
            cnt_pause = (cnt_value == '0);
         end
         default: ;
      endcase
   end

`ifdef TIMER_SHARE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         served_cnt <= '0;
      end else if (done != '0 && served_cnt != 16'hFFFF) begin
         served_cnt <= served_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_timer_share_scheduler.sv
// Directed bench for timer_share_scheduler with a behavioural model of the shared counter.
module tb_timer_share_scheduler;
   localparam int N   = 8;
   localparam int REQ = 4;
   localparam int PW  = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [REQ-1:0]   req = '0;
   logic [REQ*N-1:0] req_value = '0;
   logic [REQ-1:0]   grant;
   logic [REQ-1:0]   done;
   logic             busy;
   logic [N-1:0]     cnt = '0;
   logic             cnt_preset;
   logic [N-1:0]     cnt_preset_value;
   logic             cnt_up_en;
   logic             cnt_dn_en;
   logic             cnt_pause;
   logic             wrapped = 1'b0;
`ifdef TIMER_SHARE_STATS_EN
   logic [15:0]      served_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   timer_share_scheduler #(.N(N), .REQ(REQ), .PW(PW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .req_value(req_value),
      .grant(grant),
      .done(done),
      .busy(busy),
      .cnt_value(cnt),
      .cnt_preset(cnt_preset),
      .cnt_preset_value(cnt_preset_value),
      .cnt_up_en(cnt_up_en),
      .cnt_dn_en(cnt_dn_en),
      .cnt_pause(cnt_pause)
`ifdef TIMER_SHARE_STATS_EN
      ,
      .served_cnt(served_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Shared multifunction counter the scheduler drives.
   always @(posedge clk) begin
      if (cnt_preset) begin
         cnt <= cnt_preset_value;
      end else if (!cnt_pause && cnt_dn_en) begin
         if (cnt == '0) wrapped <= 1'b1;
         cnt <= cnt - 1'b1;
      end else if (!cnt_pause && cnt_up_en) begin
         cnt <= cnt + 1'b1;
      end
   end

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_job(input int idx, input logic [7:0] v, input bit abort);
      int t;
      req_value[idx*8 +: 8] = v;
      req = 4'b0001 << idx;
      if (abort) begin
         @(negedge clk);
         @(negedge clk);
      end else begin
         t = 0;
         @(negedge clk);
         while (done === 4'b0000 && t < 300) begin
            @(negedge clk);
            t++;
         end
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      req   = '0;
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got %b want 0000", grant); end
      n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL reset_done got %b want 0000", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if ({cnt_pause, cnt_dn_en, cnt_preset, cnt_up_en} !== 4'b1000) begin
         n_bad++; $display("FAIL reset_ctrl got pause/dn/preset/up %b want 1000", {cnt_pause, cnt_dn_en, cnt_preset, cnt_up_en});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000) begin
         n_bad++; $display("FAIL idle_after_reset got busy %b grant %b want 0 0000", busy, grant);
      end
   endtask

   task automatic test_single();
      int t;
      req_value[0 +: 8] = 8'd5;
      req = 4'b0001;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", grant); end
      n_cmp++; if (cnt_preset !== 1'b1 || cnt_preset_value !== 8'd5 || cnt_pause !== 1'b0) begin
         n_bad++; $display("FAIL single_load got preset %b value %0d pause %b want 1 5 0", cnt_preset, cnt_preset_value, cnt_pause);
      end
      t = 0;
      while (done === 4'b0000 && t < 40) begin
         @(negedge clk);
         t++;
      end
      n_cmp++; if (t != 7) begin n_bad++; $display("FAIL single_latency got %0d want 7", t); end
      n_cmp++; if (done !== 4'b0001) begin n_bad++; $display("FAIL single_done got %b want 0001", done); end
      n_cmp++; if (cnt !== 8'd0 || cnt_pause !== 1'b1) begin
         n_bad++; $display("FAIL single_cnt_at_done got cnt %0d pause %b want 0 1", cnt, cnt_pause);
      end
      req = '0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000 || done !== 4'b0000) begin
         n_bad++; $display("FAIL single_after got busy %b grant %b done %b want 0 0000 0000", busy, grant, done);
      end
   endtask

   task automatic test_zero();
      int t;
      req_value[16 +: 8] = 8'd0;
      req = 4'b0100;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0100 || cnt_preset_value !== 8'd0) begin
         n_bad++; $display("FAIL zero_grant got grant %b value %0d want 0100 0", grant, cnt_preset_value);
      end
      @(negedge clk);
      t = 1;
      n_cmp++; if (cnt_pause !== 1'b1 || cnt_dn_en !== 1'b1 || cnt !== 8'd0) begin
         n_bad++; $display("FAIL zero_run got pause %b dn %b cnt %0d want 1 1 0", cnt_pause, cnt_dn_en, cnt);
      end
      while (done === 4'b0000 && t < 40) begin
         @(negedge clk);
         t++;
      end
      n_cmp++; if (t != 2 || done !== 4'b0100) begin
         n_bad++; $display("FAIL zero_done got latency %0d done %b want 2 0100", t, done);
      end
      req = '0;
      @(negedge clk);
      n_cmp++; if (cnt !== 8'd0) begin n_bad++; $display("FAIL zero_nowrap got cnt %0d want 0", cnt); end
   endtask

   task automatic test_round_robin();
      int t;
      logic [3:0] exp_g;
      do_reset();
      req_value = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         t = 0;
         while (grant === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_cmp++; if (grant !== exp_g || t != 1) begin
            n_bad++; $display("FAIL rr_grant%0d got %b after %0d want %b after 1", g, grant, t, exp_g);
         end
         t = 0;
         while (done === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_cmp++; if (done !== exp_g || t != 3) begin
            n_bad++; $display("FAIL rr_done%0d got %b after %0d want %b after 3", g, done, t, exp_g);
         end
         @(negedge clk);
         n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rr_gap%0d got grant %b busy %b want 0000 0", g, grant, busy);
         end
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      bit saw_done;
      saw_done = 1'b0;
      do_reset();
      req_value[8 +: 8]  = 8'd20;
      req_value[24 +: 8] = 8'd2;
      req = 4'b0010;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL abort_grant got %b want 0010", grant); end
      req = 4'b1010;
      repeat (5) begin
         @(negedge clk);
         if (done !== 4'b0000) saw_done = 1'b1;
      end
      n_cmp++; if (cnt !== 8'd16 || cnt_pause !== 1'b0) begin
         n_bad++; $display("FAIL abort_running got cnt %0d pause %b want 16 0", cnt, cnt_pause);
      end
      req = 4'b1000;
      @(negedge clk);
      if (done !== 4'b0000) saw_done = 1'b1;
      n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0 || cnt_pause !== 1'b1) begin
         n_bad++; $display("FAIL abort_idle got grant %b busy %b pause %b want 0000 0 1", grant, busy, cnt_pause);
      end
      n_cmp++; if (saw_done) begin n_bad++; $display("FAIL abort_nodone got a done pulse want none"); end
      @(negedge clk);
      n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL abort_next_grant got %b want 1000", grant); end
      repeat (4) @(negedge clk);
      n_cmp++; if (done !== 4'b1000) begin n_bad++; $display("FAIL abort_next_done got %b want 1000", done); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      bit saw_done;
      saw_done = 1'b0;
      do_reset();
      run_job(1, 8'd1, 1'b0);
      req_value[0 +: 8] = 8'd20;
      req = 4'b0001;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rst_pre_grant got %b want 0001", grant); end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rst_async got grant %b done %b busy %b want 0000 0000 0", grant, done, busy);
      end
      req = '0;
      repeat (2) begin
         @(negedge clk);
         if (done !== 4'b0000) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      req_value[8 +: 8]  = 8'd1;
      req_value[16 +: 8] = 8'd1;
      req = 4'b0110;
      @(negedge clk);
      if (done !== 4'b0000) saw_done = 1'b1;
      n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL rst_rr_grant got %b want 0010", grant); end
      n_cmp++; if (saw_done) begin n_bad++; $display("FAIL rst_nodone got a done pulse want none"); end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

`ifdef TIMER_SHARE_STATS_EN
   task automatic test_stats();
      do_reset();
      n_cmp++; if (served_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_reset got %0d want 0", served_cnt); end
      run_job(0, 8'd1, 1'b0);
      run_job(1, 8'd2, 1'b0);
      run_job(2, 8'd30, 1'b1);
      run_job(3, 8'd0, 1'b0);
      n_cmp++; if (served_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_count got %0d want 3", served_cnt); end
   endtask
`endif

   task automatic test_no_wrap();
      n_cmp++; if (wrapped !== 1'b0 || cnt_up_en !== 1'b0) begin
         n_bad++; $display("FAIL no_wrap got wrapped %b up_en %b want 0 0", wrapped, cnt_up_en);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_round_robin();
      test_abort();
      test_reset_mid_run();
`ifdef TIMER_SHARE_STATS_EN
      test_stats();
`endif
      test_no_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
